// File: rtl/ramio_pkg.sv
// Shared encodings for the RAMIO request interface and the responder FSM.
package ramio_pkg;

  localparam logic [1:0] WT_NONE = 2'b00;
  localparam logic [1:0] WT_BYTE = 2'b01;
  localparam logic [1:0] WT_HALF = 2'b10;
  localparam logic [1:0] WT_WORD = 2'b11;

  localparam logic [1:0] RT_BYTE = 2'b01;
  localparam logic [1:0] RT_HALF = 2'b10;
  localparam logic [1:0] RT_WORD = 2'b11;

  localparam int unsigned RD_SIGN_BIT = 2;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_WAIT   = 3'd1,
    ST_ACCESS = 3'd2,
    ST_RESP   = 3'd3,
    ST_H1     = 3'd4,
    ST_H2     = 3'd5
  } ramio_state_e;

endpackage

// File: rtl/bram_be.sv
// Single-port 32-bit block RAM with per-byte write enables and a registered read port.
module bram_be #(
  parameter int unsigned DEPTH_WORDS = 2048,
  parameter              INIT_FILE   = ""
) (
  input  logic                           clk,
  input  logic [3:0]                     we,
  input  logic [$clog2(DEPTH_WORDS)-1:0] addr,
  input  logic [31:0]                    wdata,
  output logic [31:0]                    rdata
);

  logic [31:0] mem [DEPTH_WORDS];
  logic [31:0] rdata_q;

  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (we[i]) begin
        mem[addr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
    rdata_q <= mem[addr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/ramio_bram_responder.sv
// RAMIO responder: serves byte/half/word loads and stores from block RAM plus one LED register.
module ramio_bram_responder
  import ramio_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 2048,
  parameter int unsigned WAIT_STATES = 0,
  parameter logic [31:0] LED_ADDR    = 32'hFFFF_FFFF,
  parameter              INIT_FILE   = ""
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ramio_enable,
  input  logic [1:0]  ramio_write_type,
  input  logic [2:0]  ramio_read_type,
  input  logic [31:0] ramio_address,
  input  logic [31:0] ramio_data_in,
  output logic [31:0] ramio_data_out,
  output logic        ramio_data_out_ready,
  output logic        ramio_busy,
  output logic        led
);

  localparam int unsigned IDX_W     = $clog2(DEPTH_WORDS);
  localparam int unsigned BYTE_AW   = IDX_W + 2;
  localparam logic [32:0] RAM_BYTES = 33'(DEPTH_WORDS) << 2;
  localparam int unsigned CNT_W     = (WAIT_STATES > 1) ? $clog2(WAIT_STATES) : 1;
  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);

  ramio_state_e     state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      addr_q, addr_d;
  logic [31:0]      wdata_q, wdata_d;
  logic [1:0]       wtype_q, wtype_d;
  logic [2:0]       rtype_q, rtype_d;
  logic [31:0]      data_out_q, data_out_d;
  logic             ready_q, ready_d;
  logic             led_q, led_d;

  logic             req_valid;
  logic             is_write;
  logic             in_range;
  logic             is_led;
  logic [IDX_W-1:0] ram_idx;
  logic [3:0]       byte_en;
  logic [3:0]       ram_we;
  logic [31:0]      ram_wdata;
  logic [31:0]      ram_rdata;
  logic [31:0]      shifted;
  logic [7:0]       byte_v;
  logic [15:0]      half_v;
  logic             sign_ext;
  logic [31:0]      load_value;

  // Address decode and store lane steering for the latched request.
  always_comb begin
    is_write = (wtype_q != WT_NONE);
    in_range = ({1'b0, addr_q} < RAM_BYTES);
    is_led   = (addr_q == LED_ADDR);
    ram_idx  = addr_q[BYTE_AW-1:2];
    case (wtype_q)
      WT_BYTE: begin
        byte_en   = 4'b0001 << addr_q[1:0];
        ram_wdata = {4{wdata_q[7:0]}};
      end
      WT_HALF: begin
        byte_en   = addr_q[1] ? 4'b1100 : 4'b0011;
        ram_wdata = {2{wdata_q[15:0]}};
      end
      default: begin
        byte_en   = 4'b1111;
        ram_wdata = wdata_q;
      end
    endcase
    // A reset landing on the ACCESS edge must not let the write through.
    ram_we = (state_q == ST_ACCESS && is_write && in_range && !is_led && !rst)
             ? byte_en : 4'b0000;
  end

  // Load lane select and extension of the word read in ACCESS.
  always_comb begin
    shifted  = ram_rdata >> {addr_q[1:0], 3'b000};
    byte_v   = shifted[7:0];
    half_v   = addr_q[1] ? ram_rdata[31:16] : ram_rdata[15:0];
    sign_ext = rtype_q[RD_SIGN_BIT];
    case (rtype_q[1:0])
      RT_BYTE: load_value = {{24{sign_ext & byte_v[7]}}, byte_v};
      RT_HALF: load_value = {{16{sign_ext & half_v[15]}}, half_v};
      default: load_value = ram_rdata;
    endcase
    if (is_led) begin
      load_value = {31'b0, led_q};
    end else if (!in_range) begin
      load_value = 32'h0;
    end
  end

  // Next-state and datapath register updates.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    wtype_d    = wtype_q;
    rtype_d    = rtype_q;
    data_out_d = data_out_q;
    ready_d    = 1'b0;
    led_d      = led_q;
    req_valid  = ramio_enable &&
                 (ramio_write_type != WT_NONE || ramio_read_type != 3'b000);
    ramio_busy = 1'b0;

    case (state_q)
      ST_IDLE: begin
        ramio_busy = req_valid;
        if (req_valid) begin
          addr_d  = ramio_address;
          wdata_d = ramio_data_in;
          wtype_d = ramio_write_type;
          // A simultaneous read is discarded: stores take priority.
          rtype_d = (ramio_write_type != WT_NONE) ? 3'b000 : ramio_read_type;
          cnt_d   = '0;
          state_d = (WAIT_STATES > 0) ? ST_WAIT : ST_ACCESS;
        end
      end
      ST_WAIT: begin
        ramio_busy = 1'b1;
        if (cnt_q == WAIT_LAST) begin
          state_d = ST_ACCESS;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_ACCESS: begin
        ramio_busy = 1'b1;
        if (is_write && is_led) begin
          led_d = wdata_q[0];
        end
        state_d = is_write ? ST_H1 : ST_RESP;
      end
      ST_RESP: begin
        ramio_busy = 1'b1;
        data_out_d = load_value;
        ready_d    = 1'b1;
        state_d    = ST_H1;
      end
      // Enable is ignored here: the initiator may still be holding its last request.
      ST_H1:   state_d = ST_H2;
      ST_H2:   state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      addr_q     <= 32'h0;
      wdata_q    <= 32'h0;
      wtype_q    <= WT_NONE;
      rtype_q    <= 3'b000;
      data_out_q <= 32'h0;
      ready_q    <= 1'b0;
      led_q      <= 1'b1;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      wtype_q    <= wtype_d;
      rtype_q    <= rtype_d;
      data_out_q <= data_out_d;
      ready_q    <= ready_d;
      led_q      <= led_d;
    end
  end

  bram_be #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .INIT_FILE   (INIT_FILE)
  ) u_bram (
    .clk   (clk),
    .we    (ram_we),
    .addr  (ram_idx),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

  assign ramio_data_out       = data_out_q;
  assign ramio_data_out_ready = ready_q;
  assign led                  = led_q;

endmodule

// File: tb/tb_ramio_bram_responder.sv
// Directed bench for ramio_bram_responder: one instance with no wait states, one with three.
module tb_ramio_bram_responder;

  localparam logic [1:0] SB  = 2'b01;
  localparam logic [1:0] SH  = 2'b10;
  localparam logic [1:0] SW  = 2'b11;
  localparam logic [2:0] LB  = 3'b101;
  localparam logic [2:0] LBU = 3'b001;
  localparam logic [2:0] LH  = 3'b110;
  localparam logic [2:0] LHU = 3'b010;
  localparam logic [2:0] LW  = 3'b011;

  logic        clk = 1'b0;
  logic        rst;
  logic        en0, en3;
  logic [1:0]  wt;
  logic [2:0]  rt;
  logic [31:0] addr, din;
  logic [31:0] dout0, dout3;
  logic        rdy0, rdy3, busy0, busy3, led0, led3;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  ramio_bram_responder #(.WAIT_STATES(0)) dut0 (
    .clk(clk), .rst(rst), .ramio_enable(en0), .ramio_write_type(wt),
    .ramio_read_type(rt), .ramio_address(addr), .ramio_data_in(din),
    .ramio_data_out(dout0), .ramio_data_out_ready(rdy0), .ramio_busy(busy0), .led(led0)
  );

  ramio_bram_responder #(.WAIT_STATES(3)) dut3 (
    .clk(clk), .rst(rst), .ramio_enable(en3), .ramio_write_type(wt),
    .ramio_read_type(rt), .ramio_address(addr), .ramio_data_in(din),
    .ramio_data_out(dout3), .ramio_data_out_ready(rdy3), .ramio_busy(busy3), .led(led3)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic get_busy(input bit s);
    return s ? busy3 : busy0;
  endfunction

  function automatic logic get_rdy(input bit s);
    return s ? rdy3 : rdy0;
  endfunction

  task automatic set_en(input bit s, input logic v);
    if (s) en3 = v;
    else   en0 = v;
  endtask

  // Issue one request in an IDLE cycle and follow it to completion and back to IDLE.
  task automatic do_req(input bit s, input logic [1:0] w, input logic [2:0] r,
                        input logic [31:0] a, input logic [31:0] d,
                        output logic [31:0] q, output int lat);
    logic done;
    wt = w; rt = r; addr = a; din = d;
    set_en(s, 1'b1);
    #1;
    n_cmp++;
    if (get_busy(s) !== 1'b1) begin
      n_err++;
      $display("FAIL busy_on_accept dut%0d a=%h got %b want 1", s ? 3 : 0, a, get_busy(s));
    end
    step();
    set_en(s, 1'b0);
    #1;
    lat  = 1;
    done = 1'b0;
    while (!done && lat < 20) begin
      done = (w != 2'b00) ? (get_busy(s) === 1'b0) : (get_rdy(s) === 1'b1);
      if (!done) begin
        step();
        lat++;
      end
    end
    if (!done) begin
      n_cmp++;
      n_err++;
      $display("FAIL completion_timeout dut%0d a=%h got none want done within 20", s ? 3 : 0, a);
    end
    q = s ? dout3 : dout0;
    step();
    if (w == 2'b00) begin
      n_cmp++;
      if (get_rdy(s) !== 1'b0) begin
        n_err++;
        $display("FAIL ready_pulse_width dut%0d got %b want 0", s ? 3 : 0, get_rdy(s));
      end
    end
    step();
  endtask

  task automatic test_reset();
    rst = 1'b1; en0 = 1'b0; en3 = 1'b0;
    wt = 2'b00; rt = 3'b000; addr = 32'h0; din = 32'h0;
    step();
    rst = 1'b0;
    #1;
    n_cmp++; if (busy0 !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b want 0", busy0); end
    n_cmp++; if (rdy0 !== 1'b0) begin n_err++; $display("FAIL reset_ready got %b want 0", rdy0); end
    n_cmp++; if (dout0 !== 32'h0) begin n_err++; $display("FAIL reset_data got %h want 00000000", dout0); end
    n_cmp++; if (led0 !== 1'b1) begin n_err++; $display("FAIL reset_led got %b want 1", led0); end
    n_cmp++; if (busy3 !== 1'b0 || led3 !== 1'b1) begin
      n_err++; $display("FAIL reset_dut3 got busy=%b led=%b want busy=0 led=1", busy3, led3);
    end
    step();
  endtask

  task automatic test_loads();
    logic [31:0] q;
    int lat;
    do_req(0, SW, 3'b000, 32'h10, 32'h8040_2010, q, lat);
    do_req(0, 2'b00, LB, 32'h13, 32'h0, q, lat);
    n_cmp++; if (q !== 32'hFFFF_FF80) begin n_err++; $display("FAIL lb_0x13 got %h want ffffff80", q); end
    do_req(0, 2'b00, LBU, 32'h13, 32'h0, q, lat);
    n_cmp++; if (q !== 32'h0000_0080) begin n_err++; $display("FAIL lbu_0x13 got %h want 00000080", q); end
    do_req(0, 2'b00, LH, 32'h12, 32'h0, q, lat);
    n_cmp++; if (q !== 32'hFFFF_8040) begin n_err++; $display("FAIL lh_0x12 got %h want ffff8040", q); end
    do_req(0, 2'b00, LHU, 32'h10, 32'h0, q, lat);
    n_cmp++; if (q !== 32'h0000_2010) begin n_err++; $display("FAIL lhu_0x10 got %h want 00002010", q); end
    n_cmp++; if (dout0 !== 32'h0000_2010) begin n_err++; $display("FAIL data_hold got %h want 00002010", dout0); end
  endtask

  task automatic test_partial_stores();
    logic [31:0] q;
    int lat;
    do_req(0, SW, 3'b000, 32'h20, 32'h1122_3344, q, lat);
    do_req(0, SB, 3'b000, 32'h21, 32'h0000_00AB, q, lat);
    do_req(0, 2'b00, LW, 32'h20, 32'h0, q, lat);
    n_cmp++; if (q !== 32'h1122_AB44) begin n_err++; $display("FAIL sb_merge got %h want 1122ab44", q); end
    do_req(0, SH, 3'b000, 32'h22, 32'h0000_BEEF, q, lat);
    do_req(0, 2'b00, LW, 32'h20, 32'h0, q, lat);
    n_cmp++; if (q !== 32'hBEEF_AB44) begin n_err++; $display("FAIL sh_merge got %h want beefab44", q); end
    // Both types set: store wins, no read response.
    do_req(0, SB, LW, 32'h23, 32'h0000_0012, q, lat);
    do_req(0, 2'b00, LW, 32'h20, 32'h0, q, lat);
    n_cmp++; if (q !== 32'h12EF_AB44) begin n_err++; $display("FAIL write_wins got %h want 12efab44", q); end
  endtask

  task automatic test_latency();
    logic [31:0] q;
    int lat;
    do_req(0, SW, 3'b000, 32'h8, 32'h0000_55AA, q, lat);
    n_cmp++; if (lat !== 2) begin n_err++; $display("FAIL lat_write_ws0 got %0d want 2", lat); end
    do_req(0, 2'b00, LW, 32'h8, 32'h0, q, lat);
    n_cmp++; if (lat !== 3) begin n_err++; $display("FAIL lat_read_ws0 got %0d want 3", lat); end
    do_req(1, SW, 3'b000, 32'h8, 32'hA5A5_0F0F, q, lat);
    n_cmp++; if (lat !== 5) begin n_err++; $display("FAIL lat_write_ws3 got %0d want 5", lat); end
    do_req(1, 2'b00, LHU, 32'hA, 32'h0, q, lat);
    n_cmp++; if (lat !== 6) begin n_err++; $display("FAIL lat_read_ws3 got %0d want 6", lat); end
    n_cmp++; if (q !== 32'h0000_A5A5) begin n_err++; $display("FAIL ws3_lhu got %h want 0000a5a5", q); end
  endtask

  task automatic test_hold();
    logic [31:0] q;
    int lat;
    wt = SW; rt = 3'b000; addr = 32'h30; din = 32'h7; en0 = 1'b1;
    #1;
    n_cmp++; if (busy0 !== 1'b1) begin n_err++; $display("FAIL hold_accept got %b want 1", busy0); end
    step(); // ACCESS
    step(); // H1
    n_cmp++; if (busy0 !== 1'b0) begin n_err++; $display("FAIL hold_h1 got %b want 0", busy0); end
    step(); // H2
    n_cmp++; if (busy0 !== 1'b0) begin n_err++; $display("FAIL hold_h2 got %b want 0", busy0); end
    step(); // IDLE, same request re-accepted
    n_cmp++; if (busy0 !== 1'b1) begin n_err++; $display("FAIL hold_reaccept got %b want 1", busy0); end
    step(); // ACCESS
    n_cmp++; if (busy0 !== 1'b1) begin n_err++; $display("FAIL hold_reaccess got %b want 1", busy0); end
    step(); // H1: present a different request
    addr = 32'h34; din = 32'h55;
    #1;
    n_cmp++; if (busy0 !== 1'b0) begin n_err++; $display("FAIL changed_h1 got %b want 0", busy0); end
    step(); // H2
    n_cmp++; if (busy0 !== 1'b0) begin n_err++; $display("FAIL changed_h2 got %b want 0", busy0); end
    step(); // IDLE, changed request accepted
    n_cmp++; if (busy0 !== 1'b1) begin n_err++; $display("FAIL changed_accept got %b want 1", busy0); end
    step(); // ACCESS
    en0 = 1'b0;
    #1;
    n_cmp++; if (busy0 !== 1'b1) begin n_err++; $display("FAIL changed_access got %b want 1", busy0); end
    step(); step(); step();
    do_req(0, 2'b00, LW, 32'h34, 32'h0, q, lat);
    n_cmp++; if (q !== 32'h0000_0055) begin n_err++; $display("FAIL changed_data got %h want 00000055", q); end
    do_req(0, 2'b00, LW, 32'h30, 32'h0, q, lat);
    n_cmp++; if (q !== 32'h0000_0007) begin n_err++; $display("FAIL held_data got %h want 00000007", q); end
  endtask

  task automatic test_edges();
    logic [31:0] q;
    int lat;
    do_req(0, SW, 3'b000, 32'h0, 32'h0102_0304, q, lat);
    do_req(0, SW, 3'b000, 32'h2000, 32'hCAFE_F00D, q, lat);
    n_cmp++; if (lat !== 2) begin n_err++; $display("FAIL oor_write_lat got %0d want 2", lat); end
    do_req(0, 2'b00, LW, 32'h0, 32'h0, q, lat);
    n_cmp++; if (q !== 32'h0102_0304) begin n_err++; $display("FAIL oor_no_alias got %h want 01020304", q); end
    do_req(0, 2'b00, LW, 32'h2000, 32'h0, q, lat);
    n_cmp++; if (q !== 32'h0) begin n_err++; $display("FAIL oor_read got %h want 00000000", q); end
    n_cmp++; if (lat !== 3) begin n_err++; $display("FAIL oor_read_lat got %0d want 3", lat); end
    do_req(0, SB, 3'b000, 32'hFFFF_FFFF, 32'h0, q, lat);
    n_cmp++; if (led0 !== 1'b0) begin n_err++; $display("FAIL led_clear got %b want 0", led0); end
    do_req(0, 2'b00, LBU, 32'hFFFF_FFFF, 32'h0, q, lat);
    n_cmp++; if (q !== 32'h0) begin n_err++; $display("FAIL led_read0 got %h want 00000000", q); end
    do_req(0, SW, 3'b000, 32'hFFFF_FFFF, 32'h3, q, lat);
    n_cmp++; if (led0 !== 1'b1) begin n_err++; $display("FAIL led_set got %b want 1", led0); end
    do_req(0, 2'b00, LB, 32'hFFFF_FFFF, 32'h0, q, lat);
    n_cmp++; if (q !== 32'h0000_0001) begin n_err++; $display("FAIL led_read1 got %h want 00000001", q); end
    do_req(0, SB, 3'b000, 32'hFFFF_FFFF, 32'h2, q, lat);
    n_cmp++; if (led0 !== 1'b0) begin n_err++; $display("FAIL led_bit0_only got %b want 0", led0); end
  endtask

  task automatic test_reset_mid_write();
    logic [31:0] q;
    int lat;
    do_req(1, SW, 3'b000, 32'h40, 32'h0123_4567, q, lat);
    wt = SW; rt = 3'b000; addr = 32'h40; din = 32'hDEAD_BEEF; en3 = 1'b1;
    step(); // first WAIT cycle
    en3 = 1'b0;
    step(); // second WAIT cycle
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    n_cmp++; if (busy3 !== 1'b0) begin n_err++; $display("FAIL rst_abort_busy got %b want 0", busy3); end
    n_cmp++; if (led0 !== 1'b1) begin n_err++; $display("FAIL rst_led_restore got %b want 1", led0); end
    n_cmp++; if (dout0 !== 32'h0) begin n_err++; $display("FAIL rst_data_clear got %h want 00000000", dout0); end
    step(); step(); step(); step();
    do_req(1, 2'b00, LW, 32'h40, 32'h0, q, lat);
    n_cmp++; if (q !== 32'h0123_4567) begin n_err++; $display("FAIL rst_no_commit got %h want 01234567", q); end
  endtask

  initial begin
    test_reset();
    test_loads();
    test_partial_stores();
    test_latency();
    test_hold();
    test_edges();
    test_reset_mid_write();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
